// File: rtl/v74x139_half_dec_reg.sv
`default_nettype none
// ============================================================================
// Module   : v74x139_half_dec_reg
// Purpose  : Registered half of a 74x139 dual 2-to-4 decoder with an
//            active-low enable and an active-low one-cold output.
// Revision : 1.0  initial release
// ============================================================================
module v74x139_half_dec_reg (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       G_L,
    input  logic       A,
    input  logic       B,
    output logic [3:0] Y_L
);

    localparam logic [3:0] C_ALL_OFF = 4'b1111;

    logic [3:0] r_y_l;
    logic [3:0] w_y_l_next;

    // Only clean 0/1 patterns match an explicit item. Unknown inputs fall
    // through to the default and load all-ones, the deassert-safe state.
    always_comb begin
        w_y_l_next = C_ALL_OFF;
        case ({G_L, B, A})
            3'b000:  w_y_l_next = 4'b1110;
            3'b001:  w_y_l_next = 4'b1101;
            3'b010:  w_y_l_next = 4'b1011;
            3'b011:  w_y_l_next = 4'b0111;
            default: w_y_l_next = C_ALL_OFF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_y_l <= C_ALL_OFF;
        end else begin
            r_y_l <= w_y_l_next;
        end
    end

    assign Y_L = r_y_l;

endmodule
`default_nettype wire

// File: tb/tb_v74x139_half_dec_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_v74x139_half_dec_reg
// Purpose  : Directed self-checking bench for v74x139_half_dec_reg.
// Revision : 1.0  initial release
// ============================================================================
module tb_v74x139_half_dec_reg;

    logic       CLK;
    logic       RESET;
    logic       G_L;
    logic       A;
    logic       B;
    logic [3:0] Y_L;

    int checks = 0;
    int errors = 0;
    bit inv_en = 1'b0;

    v74x139_half_dec_reg dut (
        .CLK   (CLK),
        .RESET (RESET),
        .G_L   (G_L),
        .A     (A),
        .B     (B),
        .Y_L   (Y_L)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs just after an edge, then sample just after the next edge.
    task automatic apply(input string tag, input logic g, input logic b, input logic a,
                         input logic [3:0] exp);
        G_L = g;
        B   = b;
        A   = a;
        @(posedge CLK);
        #1;
        check(tag, Y_L, exp);
    endtask

    // One-cold invariant, sampled on the falling edge.
    always @(negedge CLK) begin
        if (inv_en) begin
            check("onecold", {3'b000, ($countones(~Y_L) <= 1)}, 4'b0001);
        end
    end

    initial begin
        RESET = 1'b1;
        G_L   = 1'b0;
        A     = 1'b1;
        B     = 1'b1;

        // Reset with an otherwise-decoding input pattern
        @(posedge CLK);
        #1;
        check("reset_e1", Y_L, 4'b1111);
        inv_en = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_e2", Y_L, 4'b1111);
        RESET = 1'b0;
        apply("reset_release", 1'b0, 1'b1, 1'b1, 4'b0111);

        // Full decode sweep
        apply("dec_00", 1'b0, 1'b0, 1'b0, 4'b1110);
        apply("dec_01", 1'b0, 1'b0, 1'b1, 4'b1101);
        apply("dec_10", 1'b0, 1'b1, 1'b0, 4'b1011);
        apply("dec_11", 1'b0, 1'b1, 1'b1, 4'b0111);

        // Disable sweep
        apply("dis_00", 1'b1, 1'b0, 1'b0, 4'b1111);
        apply("dis_10", 1'b1, 1'b1, 1'b0, 4'b1111);
        apply("dis_01", 1'b1, 1'b0, 1'b1, 4'b1111);
        apply("dis_11", 1'b1, 1'b1, 1'b1, 4'b1111);

        // Enable toggle with A=1, B=0
        apply("tog_0", 1'b0, 1'b0, 1'b1, 4'b1101);
        apply("tog_1", 1'b1, 1'b0, 1'b1, 4'b1111);
        apply("tog_2", 1'b0, 1'b0, 1'b1, 4'b1101);

        // Reset mid-operation
        apply("mid_sel", 1'b0, 1'b1, 1'b0, 4'b1011);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_reset", Y_L, 4'b1111);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("mid_resume", Y_L, 4'b1011);

        // Input change between edges must not reach the output early
        apply("samp_base", 1'b0, 1'b0, 1'b0, 4'b1110);
        #2;
        A = 1'b1;
        #1;
        check("samp_hold", Y_L, 4'b1110);
        @(posedge CLK);
        #1;
        check("samp_next", Y_L, 4'b1101);

        // Back-to-back select changes, no all-ones gap
        apply("b2b_0", 1'b0, 1'b1, 1'b1, 4'b0111);
        apply("b2b_1", 1'b0, 1'b0, 1'b0, 4'b1110);
        apply("b2b_2", 1'b0, 1'b1, 1'b0, 4'b1011);

        inv_en = 1'b0;
        @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
